// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory among NUM_REQ requesters.
// It runs one transaction at a time, absorbs the memory read latency and returns a one-cycle response.
module mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ-1:0]          req_rd_wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        mem_enable_o,
  output logic                        mem_rd_wr_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wr_data_o,
  input  logic [DATA_W-1:0]           mem_rd_data_i,
  output logic                        busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    cand;
  logic                found;

  // Scan starts just after the previous winner so priority rotates.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    mem_enable_d  = 1'b0;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rsp_rdata_d   = rsp_rdata_q;
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_o[winner] = 1'b1;
          owner_d       = winner;
          last_grant_d  = winner;
          mem_enable_d  = 1'b1;
          mem_rd_wr_d   = req_rd_wr_i[winner];
          mem_addr_d    = req_addr_i[int'(winner)*ADDR_W +: ADDR_W];
          mem_wr_data_d = req_wdata_i[int'(winner)*DATA_W +: DATA_W];
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rd_wr_q) begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = WAIT;
        end else begin
          rsp_rdata_d = '0;
          state_d     = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_rdata_d = mem_rd_data_i;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      owner_q       <= '0;
      cnt_q         <= '0;
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      mem_enable_q  <= mem_enable_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign mem_enable_o  = mem_enable_q;
  assign mem_rd_wr_o   = mem_rd_wr_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign busy_o        = (state_q != IDLE);

endmodule
